// File: rtl/fifo_rd.sv
// Burst reader for the byte FIFO: drains it once it reports full, forwards
// each byte to the UART over valid/ready and checks the stream is a +1 sequence.
module fifo_rd #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_full,
  input  logic             rd_empty,
  input  logic [7:0]       rd_data,
  output logic             rd_req,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             burst_done,
  output logic             seq_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [1:0] SEND  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       exp_q, exp_d;
  logic             first_q, first_d;

  // Read only while in REQ and data is available, so the FIFO never underflows.
  assign rd_req     = (state_q == REQ) & ~rd_empty;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign byte_cnt   = cnt_q;
  assign burst_done = done_q;
  assign seq_err    = err_q;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = err_q;
    exp_d      = exp_q;
    first_d    = first_q;
    case (state_q)
      IDLE: begin
        if (rd_full && !rd_empty) begin
          state_d = REQ;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      REQ: begin
        if (!rd_empty) begin
          state_d = LATCH;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      LATCH: begin
        tx_data_d  = rd_data;
        tx_valid_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        // First byte of a burst seeds the checker; a mismatch resyncs to the new value.
        if (first_q) begin
          exp_d   = rd_data + 8'd1;
          first_d = 1'b0;
        end else if (rd_data != exp_q) begin
          err_d = 1'b1;
          exp_d = rd_data + 8'd1;
        end else begin
          exp_d = exp_q + 8'd1;
        end
        state_d = SEND;
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      exp_q      <= 8'h00;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      exp_q      <= exp_d;
      first_q    <= first_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd.sv
// Scoreboard bench for fifo_rd: a small non-showahead FIFO model feeds the DUT,
// expected bytes are queued at load time and a monitor checks each TX handshake.
module tb_fifo_rd;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rd_full = 1'b0;
  logic             rd_empty = 1'b1;
  logic [7:0]       rd_data = 8'h00;
  logic             rd_req;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic [CNT_W-1:0] byte_cnt;
  logic             burst_done;
  logic             seq_err;

  fifo_rd #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rd_full(rd_full), .rd_empty(rd_empty),
    .rd_data(rd_data), .rd_req(rd_req), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .byte_cnt(byte_cnt), .burst_done(burst_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int stall = 0;
  int scnt = 0;
  int depth = 0;
  logic force_full = 1'b0;
  logic [7:0] fifo[$];
  logic [7:0] expq[$];
  int hs_cnt = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int last_req = -1;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: request sampled at the edge, data presented just after it.
  always @(posedge clk) begin
    logic req;
    req = rd_req;
    #1;
    if (req && fifo.size() > 0) rd_data = fifo.pop_front();
    rd_empty = (fifo.size() == 0);
    rd_full  = force_full | ((depth != 0) && (fifo.size() == depth));
  end

  // Sink: always ready, or hold ready low for ~5 cycles per byte.
  always @(posedge clk) begin
    #2;
    if (stall == 0) tx_ready = 1'b1;
    else if (!tx_valid) begin
      tx_ready = 1'b0;
      scnt = 0;
    end else if (!tx_ready) begin
      scnt++;
      if (scnt >= 5) tx_ready = 1'b1;
    end
  end

  // Monitor: inputs are stable at the negedge, so valid&ready here is the next handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      last_req = -1;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && rd_req) chk("rd_req_in_send", 32'd1, 32'd0);
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        if (expq.size() == 0) chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else chk("tx_data", {24'd0, tx_data}, {24'd0, expq.pop_front()});
      end
      if (rd_req) begin
        req_cnt++;
        if (stall == 0 && last_req >= 0) chk("rd_req_spacing", cyc - last_req, 32'd3);
        last_req = cyc;
      end
      if (burst_done) begin
        done_cnt++;
        last_req = -1;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_it);
    fifo.push_back(b);
    if (expect_it) expq.push_back(b);
  endtask

  task automatic load_seq(input int first, input int n);
    for (int i = 0; i < n; i++) push_byte(8'((first + i) & 255), 1'b1);
    depth = n;
  endtask

  task automatic wait_burst(input string nm, input int lim);
    int base;
    bit seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != base) seen = 1'b1;
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    chk({nm, "_done_pulses"}, done_cnt - base, 32'd1);
    chk({nm, "_sb_empty"}, expq.size(), 32'd0);
  endtask

  initial begin
    int r0, d0, h0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst_burst_done", {31'd0, burst_done}, 32'd0);
    chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
    chk("rst_byte_cnt", {23'd0, byte_cnt}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: full-speed drain of 1..16
    r0 = req_cnt;
    load_seq(1, 16);
    wait_burst("t1", 200);
    chk("t1_rd_req_count", req_cnt - r0, 32'd16);
    chk("t1_byte_cnt", {23'd0, byte_cnt}, 32'd16);
    chk("t1_seq_err", {31'd0, seq_err}, 32'd0);

    // 2: same with a stalling sink
    stall = 1;
    r0 = req_cnt; h0 = hs_cnt;
    load_seq(1, 16);
    wait_burst("t2", 400);
    chk("t2_rd_req_count", req_cnt - r0, 32'd16);
    chk("t2_transfers", hs_cnt - h0, 32'd16);
    chk("t2_byte_cnt", {23'd0, byte_cnt}, 32'd16);
    stall = 0;
    @(negedge clk);

    // 3: wrap through 0xFF -> 0x00 is legal
    load_seq(254, 4);
    wait_burst("t3", 100);
    chk("t3_seq_err", {31'd0, seq_err}, 32'd0);
    chk("t3_byte_cnt", {23'd0, byte_cnt}, 32'd4);

    // 4: 3,4,9,10 breaks the sequence; flag is sticky across a clean burst
    push_byte(8'd3, 1'b1); push_byte(8'd4, 1'b1);
    push_byte(8'd9, 1'b1); push_byte(8'd10, 1'b1);
    depth = 4;
    wait_burst("t4", 100);
    chk("t4_seq_err", {31'd0, seq_err}, 32'd1);
    load_seq(1, 16);
    wait_burst("t4b", 200);
    chk("t4b_seq_err_sticky", {31'd0, seq_err}, 32'd1);

    // 5: reset while byte 5 is waiting in SEND
    stall = 1;
    h0 = hs_cnt;
    load_seq(1, 16);
    for (int i = 0; i < 400 && !((hs_cnt - h0) == 4 && tx_valid); i++) @(negedge clk);
    chk("t5_reached_byte5", {24'd0, tx_data}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("t5_rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("t5_rst_byte_cnt", {23'd0, byte_cnt}, 32'd0);
    chk("t5_rst_seq_err", {31'd0, seq_err}, 32'd0);
    expq.delete();
    stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = req_cnt; d0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("t5_idle_rd_req", req_cnt - r0, 32'd0);
    chk("t5_idle_done", done_cnt - d0, 32'd0);
    for (int b = 6; b <= 16; b++) expq.push_back(8'(b));
    force_full = 1'b1;
    repeat (2) @(negedge clk);
    force_full = 1'b0;
    wait_burst("t5", 200);
    chk("t5_byte_cnt", {23'd0, byte_cnt}, 32'd11);
    chk("t5_seq_err", {31'd0, seq_err}, 32'd0);

    // 6: full glitch while empty must not start a drain
    depth = 0;
    r0 = req_cnt; d0 = done_cnt;
    force_full = 1'b1;
    @(negedge clk);
    force_full = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_rd_req", req_cnt - r0, 32'd0);
    chk("t6_burst_done", done_cnt - d0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
